// File: rtl/prbs_checker.sv
// prbs_checker: serial receive end of the 8-bit LFSR generator.
// It self-synchronises to the incoming bit stream, predicts each following
// bit and counts mismatches in a saturating counter.
// Optional feature macro: PRBS_SEG_EN builds registered seven-segment hex
// decoders for err_cnt[7:0]. When it is not defined, seg0/seg1 are tied off
// to all segments dark.
module prbs_checker #(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1
);

    typedef enum logic {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LOSS    = 4'(LOSS_THRESH);

    state_t           state_q;
    logic [7:0]       win_q;
    logic [2:0]       fill_q;
    logic [3:0]       miss_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;
    logic             pred;
    logic             mismatch;
    logic             lossHit;

    // Predict the next bit from the window and derive the counter's next value.
    always_comb begin
        pred     = win_q[4] ^ win_q[3] ^ win_q[2] ^ win_q[0] ^ ~|win_q[7:1];
        mismatch = en && (state_q == CHECK) && (din != pred);
        lossHit  = mismatch && ((miss_q + 4'd1) == LOSS);
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    // Hunt/check state machine with window, fill and miss counters.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= HUNT;
            win_q       <= '0;
            fill_q      <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= mismatch;
            err_cnt_q   <= err_cnt_d;
            if (en) begin
                win_q <= {din, win_q[7:1]};
                case (state_q)
                    HUNT: begin
                        if (fill_q == 3'd7) begin
                            state_q  <= CHECK;
                            locked_q <= 1'b1;
                            fill_q   <= '0;
                        end else begin
                            fill_q <= fill_q + 3'd1;
                        end
                    end
                    CHECK: begin
                        if (lossHit) begin
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                            fill_q   <= '0;
                            miss_q   <= '0;
                        end else if (mismatch) begin
                            miss_q <= miss_q + 4'd1;
                        end else begin
                            miss_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef PRBS_SEG_EN
    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0: hexSeg = 7'b1000000;
            4'h1: hexSeg = 7'b1111001;
            4'h2: hexSeg = 7'b0100100;
            4'h3: hexSeg = 7'b0110000;
            4'h4: hexSeg = 7'b0011001;
            4'h5: hexSeg = 7'b0010010;
            4'h6: hexSeg = 7'b0000010;
            4'h7: hexSeg = 7'b1111000;
            4'h8: hexSeg = 7'b0000000;
            4'h9: hexSeg = 7'b0010000;
            4'hA: hexSeg = 7'b0001000;
            4'hB: hexSeg = 7'b0000011;
            4'hC: hexSeg = 7'b1000110;
            4'hD: hexSeg = 7'b0100001;
            4'hE: hexSeg = 7'b0000110;
            default: hexSeg = 7'b0001110;
        endcase
    endfunction

    logic [7:0] segSrc;
    logic [6:0] seg0_q;
    logic [6:0] seg1_q;

    generate
        if (CNT_W >= 8) begin : gSrcWide
            assign segSrc = err_cnt_q[7:0];
        end else begin : gSrcNarrow
            assign segSrc = {{(8 - CNT_W){1'b0}}, err_cnt_q};
        end
    endgenerate

    // Registered hex decode of the counter, one cycle behind err_cnt.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            seg0_q <= 7'b1000000;
            seg1_q <= 7'b1000000;
        end else begin
            seg0_q <= hexSeg(segSrc[3:0]);
            seg1_q <= hexSeg(segSrc[7:4]);
        end
    end

    assign seg0 = seg0_q;
    assign seg1 = seg1_q;
`else
    assign seg0 = 7'b1111111;
    assign seg1 = 7'b1111111;
`endif

endmodule
